seq_share_ctrl: RTL

//  Shares one 3-bit flip-flop sequence generator (seq_core) among N_REQ requesters.

---
 rtl/seq_share_pkg.sv | 27 ++
 rtl/seq_core.sv | 26 ++
 rtl/seq_share_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/seq_share_pkg.sv
// Shared types and the sequence-generator next-state rule for seq_share_ctrl.
// The core and the controller both use seq_next so the step rule lives in one place.
package seq_share_pkg;

  localparam int SEQ_W = 3;
  localparam logic [SEQ_W-1:0] SEQ_INIT = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } ctrl_state_t;

  // State vector is {S0,S1,S2}, S0 in the MSB.
  function automatic logic [SEQ_W-1:0] seq_next(input logic [SEQ_W-1:0] s);
    logic s0, s1, s2;
    s0 = s[2];
    s1 = s[1];
    s2 = s[0];
    return {~(s1 | s2), s0 | s2, ~(s0 ^ ~s1)};
  endfunction

  function automatic logic seq_y(input logic [SEQ_W-1:0] s);
    return s[2] & s[1];
  endfunction

endpackage

// File: rtl/seq_core.sv
// Three-flop sequence generator: async reset, sync clear, step on en, holds otherwise.
// y_next is the y output of the state the next enabled step will produce.
module seq_core
  import seq_share_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [SEQ_W-1:0] state,
  output logic             y_next
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= SEQ_INIT;
    end else if (clr) begin
      state <= SEQ_INIT;
    end else if (en) begin
      state <= seq_next(state);
    end
  end

  assign y_next = seq_y(seq_next(state));

endmodule

// File: rtl/seq_share_ctrl.sv
// Round-robin shares one seq_core among N_REQ requesters: clear, step K times, count y=1 steps.
// Accept in cycle T gives rsp_valid at T+K+1; response holds until rsp_ready, no grants while busy.
module seq_share_ctrl
  import seq_share_pkg::*;
#(
  parameter  int N_REQ  = 4,
  parameter  int STEP_W = 8,
  localparam int ID_W   = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*STEP_W-1:0] req_steps,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [SEQ_W-1:0]        rsp_state,
  output logic [STEP_W-1:0]       rsp_ycount,
  output logic                    busy
);

  ctrl_state_t       state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   id_q;
  logic [STEP_W-1:0] remaining;
  logic [STEP_W-1:0] ycount;

  logic [ID_W-1:0]   hi_idx, lo_idx, gnt_idx;
  logic              hi_any, lo_any, gnt_any;
  logic [STEP_W-1:0] k_sel;
  logic              accept;
  logic [SEQ_W-1:0]  core_state;
  logic              core_y_next;

  // Lowest valid index above the pointer wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hi_idx = '0;
    hi_any = 1'b0;
    lo_idx = '0;
    lo_any = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = ID_W'(i);
        lo_any = 1'b1;
        if (i > int'(rr_ptr)) begin
          hi_idx = ID_W'(i);
          hi_any = 1'b1;
        end
      end
    end
    gnt_any = lo_any;
    gnt_idx = hi_any ? hi_idx : lo_idx;
  end

  always_comb begin
    k_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        k_sel = req_steps[i*STEP_W +: STEP_W];
      end
    end
  end

  assign accept = (state == IDLE) && gnt_any;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = accept && !reset && (gnt_idx == ID_W'(i));
    end
  end

  seq_core u_core (
    .clk    (clk),
    .reset  (reset),
    .clr    (accept),
    .en     (state == RUN),
    .state  (core_state),
    .y_next (core_y_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      remaining <= '0;
      ycount    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            id_q      <= gnt_idx;
            remaining <= k_sel;
            ycount    <= '0;
            state     <= (k_sel != '0) ? RUN : RESP;
          end
        end
        RUN: begin
          remaining <= remaining - STEP_W'(1);
          ycount    <= ycount + STEP_W'(core_y_next);
          if (remaining == STEP_W'(1)) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rr_ptr <= id_q;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_valid  = (state == RESP);
  assign busy       = (state != IDLE);
  assign rsp_id     = id_q;
  assign rsp_state  = core_state;
  assign rsp_ycount = ycount;

endmodule
